// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage: slot count, RISC-V control-flow
// opcodes, predictor state and per-slot instruction-buffer packet.
package fetch_stage_pkg;

  localparam int unsigned FETCH_N = 3;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [1:0] counter;
    logic [7:0] history;
  } bp_packet_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        predict_taken;
    bp_packet_t  bp_packet;
    logic [31:0] predicted_pc;
    logic        is_jump;
  } fetch_packet_t;

  function automatic logic is_branch_op(input logic [31:0] inst);
    return inst[6:0] == OPC_BRANCH;
  endfunction

  function automatic logic is_jump_op(input logic [31:0] inst);
    return (inst[6:0] == OPC_JAL) || (inst[6:0] == OPC_JALR);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: I-cache/BTB/predictor inputs and instruction-buffer outputs.
// The master modport is the fetch stage itself; slave is its environment.
interface fetch_stage_if
  import fetch_stage_pkg::*;
#(
  parameter int unsigned N  = FETCH_N,
  parameter int unsigned SB = $clog2(N + 1)
);

  logic [N-1:0][31:0]      PCs_out;
  logic [N-1:0][31:0]      cache_data;
  logic [N-1:0]            cache_miss;
  logic [31:0]             PC_restore;
  logic                    restore_valid;
  logic [SB-1:0]           inst_buffer_spots;
  fetch_packet_t [N-1:0]   inst_buffer_inputs;
  logic [SB-1:0]           inst_valid;
  bp_packet_t [N-1:0]      bp_packets;
  logic [N-1:0]            branches_taken;
  logic [N-1:0][N-1:0]     branch_gnt_bus;
  logic [N-1:0]            final_branch_gnt_line;
  logic                    no_branches_fetched;
  logic [N-1:0][31:0]      target_PCs;
  logic [N-1:0]            btb_hits;

  modport master (
    input  cache_data, cache_miss, PC_restore, restore_valid, inst_buffer_spots,
           bp_packets, branches_taken, target_PCs, btb_hits,
    output PCs_out, inst_buffer_inputs, inst_valid, branch_gnt_bus,
           final_branch_gnt_line, no_branches_fetched
  );

  modport slave (
    output cache_data, cache_miss, PC_restore, restore_valid, inst_buffer_spots,
           bp_packets, branches_taken, target_PCs, btb_hits,
    input  PCs_out, inst_buffer_inputs, inst_valid, branch_gnt_bus,
           final_branch_gnt_line, no_branches_fetched
  );

endinterface

// File: rtl/prio_sel.sv
// Generic priority selector: row j of gnt_bus is the one-hot of the j-th request
// found scanning from the LSB (LSB_FIRST=1) or from the MSB.
module prio_sel #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned REQS      = 1,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic [WIDTH-1:0]            req,
  output logic [WIDTH-1:0]            gnt,
  output logic [REQS-1:0][WIDTH-1:0]  gnt_bus,
  output logic                        empty
);

  logic [WIDTH-1:0] remaining;
  logic [WIDTH-1:0] pick;
  logic             found;

  function automatic int unsigned bit_at(input int unsigned b);
    return LSB_FIRST ? b : (WIDTH - 1 - b);
  endfunction

  // Peel off one request per row, removing each winner before the next scan.
  always_comb begin
    remaining = req;
    gnt_bus   = '0;
    pick      = '0;
    found     = 1'b0;
    for (int unsigned j = 0; j < REQS; j++) begin
      pick  = '0;
      found = 1'b0;
      for (int unsigned b = 0; b < WIDTH; b++) begin
        if (!found && remaining[bit_at(b)]) begin
          pick[bit_at(b)] = 1'b1;
          found           = 1'b1;
        end
      end
      gnt_bus[j] = pick;
      remaining  = remaining & ~pick;
    end
  end

  assign gnt   = gnt_bus[0];
  assign empty = ~|req;

endmodule

// File: rtl/fetch_stage.sv
// N-wide fetch stage: slot PCs, packet formation, acceptance count limited by
// misses, taken branches and buffer space, branch grants and next-PC selection.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned N  = FETCH_N,
  parameter int unsigned SB = $clog2(N + 1)
) (
  input  logic          clock,
  input  logic          reset,
  fetch_stage_if.master bus
);

  logic [31:0]          pc_reg;
  logic [31:0]          next_pc;
  logic [N:0][31:0]     slot_pc;
  logic [N-1:0]         is_br;
  logic [N-1:0]         is_jmp;
  logic [N-1:0]         limit_vec;
  logic [N-1:0]         limit_gnt;
  logic                 limit_none;
  logic [SB-1:0]        limit_idx;
  logic [SB-1:0]        raw_cnt;
  logic [SB-1:0]        valid_cnt;
  logic [N-1:0]         br_masked;
  logic [0:0][N-1:0]    limit_bus_unused;
  logic [N-1:0]         br_gnt_unused;
  logic                 br_empty_unused;
  logic [0:0][N-1:0]    final_bus_unused;

  // Slot PCs, including the one just past the last slot.
  always_comb begin
    slot_pc = '0;
    for (int unsigned i = 0; i <= N; i++) begin
      slot_pc[i] = pc_reg + 32'(4 * i);
    end
  end

  always_comb begin
    is_br  = '0;
    is_jmp = '0;
    for (int unsigned i = 0; i < N; i++) begin
      is_br[i]  = is_branch_op(bus.cache_data[i]);
      is_jmp[i] = is_jump_op(bus.cache_data[i]);
    end
  end

  // A miss stops at its own slot; a taken prediction stops after its slot.
  assign limit_vec = bus.cache_miss | (bus.branches_taken << 1);

  prio_sel #(.WIDTH(N), .REQS(1), .LSB_FIRST(1'b1)) u_limit (
    .req     (limit_vec),
    .gnt     (limit_gnt),
    .gnt_bus (limit_bus_unused),
    .empty   (limit_none)
  );

  always_comb begin
    limit_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (limit_gnt[i]) limit_idx = limit_idx | SB'(i);
    end
    raw_cnt   = limit_none ? SB'(N) : limit_idx;
    valid_cnt = (raw_cnt < bus.inst_buffer_spots) ? raw_cnt : bus.inst_buffer_spots;
  end

  assign bus.inst_valid = valid_cnt;

  always_comb begin
    bus.inst_buffer_inputs = '0;
    for (int unsigned i = 0; i < N; i++) begin
      bus.inst_buffer_inputs[i].inst          = bus.cache_data[i];
      bus.inst_buffer_inputs[i].pc            = slot_pc[i];
      bus.inst_buffer_inputs[i].predict_taken = (is_br[i] && bus.branches_taken[i]) || is_jmp[i];
      bus.inst_buffer_inputs[i].bp_packet     = bus.bp_packets[i];
      bus.inst_buffer_inputs[i].predicted_pc  = bus.btb_hits[i] ? bus.target_PCs[i] : slot_pc[i+1];
      bus.inst_buffer_inputs[i].is_jump       = is_jmp[i];
    end
  end

  always_comb begin
    bus.PCs_out = '0;
    for (int unsigned i = 0; i < N; i++) begin
      bus.PCs_out[i] = slot_pc[i];
    end
  end

  prio_sel #(.WIDTH(N), .REQS(N), .LSB_FIRST(1'b1)) u_br_bus (
    .req     (is_br),
    .gnt     (br_gnt_unused),
    .gnt_bus (bus.branch_gnt_bus),
    .empty   (br_empty_unused)
  );

  always_comb begin
    br_masked = '0;
    for (int unsigned i = 0; i < N; i++) begin
      br_masked[i] = is_br[i] && (SB'(i) < valid_cnt);
    end
  end

  prio_sel #(.WIDTH(N), .REQS(1), .LSB_FIRST(1'b0)) u_final (
    .req     (br_masked),
    .gnt     (bus.final_branch_gnt_line),
    .gnt_bus (final_bus_unused),
    .empty   (bus.no_branches_fetched)
  );

  // Fall through past the accepted slots unless the last accepted one is predicted taken.
  always_comb begin
    next_pc = pc_reg + (32'(valid_cnt) << 2);
    for (int unsigned i = 0; i < N; i++) begin
      if ((valid_cnt == SB'(i + 1)) && bus.branches_taken[i]) next_pc = bus.target_PCs[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                  pc_reg <= '0;
    else if (bus.restore_valid) pc_reg <= bus.PC_restore;
    else                        pc_reg <= next_pc;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage (N=3): hand-computed expectations checked with
// immediate assertions; inputs change on negedge, outputs sampled before posedge.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] BRANCH = 32'h0000_0063;
  localparam logic [31:0] JAL    = 32'h0000_006F;
  localparam logic [31:0] JALR   = 32'h0000_0067;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  fetch_stage_if #(.N(3), .SB(2)) ifc ();

  fetch_stage #(.N(3), .SB(2)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic defaults();
    for (int i = 0; i < 3; i++) begin
      ifc.cache_data[i] = NOP;
      ifc.target_PCs[i] = 32'h0;
      ifc.bp_packets[i] = bp_packet_t'({2'(i), 8'hA0 + 8'(i)});
    end
    ifc.cache_miss        = '0;
    ifc.branches_taken    = '0;
    ifc.btb_hits          = '0;
    ifc.inst_buffer_spots = 2'd3;
    ifc.restore_valid     = 1'b0;
    ifc.PC_restore        = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    defaults();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b0;
    defaults();

    // Reset state and plain sequential fetch
    do_reset();
    #1;
    check("rst_pc0", ifc.PCs_out[0], 32'h0);
    check("rst_pc1", ifc.PCs_out[1], 32'h4);
    check("rst_pc2", ifc.PCs_out[2], 32'h8);
    check("rst_valid", 32'(ifc.inst_valid), 32'd3);
    check("rst_nobr", 32'(ifc.no_branches_fetched), 32'd1);
    check("rst_final", 32'(ifc.final_branch_gnt_line), 32'd0);
    check("rst_gntbus", 32'(ifc.branch_gnt_bus), 32'd0);
    check("pkt1_pred_pc", ifc.inst_buffer_inputs[1].predicted_pc, 32'h8);
    check("pkt2_bp", 32'(ifc.inst_buffer_inputs[2].bp_packet), 32'h2A2);
    tick();
    check("seq_next", ifc.PCs_out[0], 32'h0C);

    // Miss in slot 2
    do_reset();
    ifc.cache_miss = 3'b100;
    #1 check("miss_valid", 32'(ifc.inst_valid), 32'd2);
    tick();
    check("miss_next", ifc.PCs_out[0], 32'h08);

    // Taken branch in slot 1
    do_reset();
    ifc.cache_data[1]     = BRANCH;
    ifc.branches_taken    = 3'b010;
    ifc.target_PCs[1]     = 32'h100;
    #1;
    check("tkn_valid", 32'(ifc.inst_valid), 32'd2);
    check("tkn_pred1", 32'(ifc.inst_buffer_inputs[1].predict_taken), 32'd1);
    check("tkn_ppc1", ifc.inst_buffer_inputs[1].predicted_pc, 32'h8);
    check("tkn_final", 32'(ifc.final_branch_gnt_line), 32'b010);
    check("tkn_nobr", 32'(ifc.no_branches_fetched), 32'd0);
    tick();
    check("tkn_next", ifc.PCs_out[0], 32'h100);

    // Taken branch in the last slot shifts out of the limit vector
    do_reset();
    ifc.cache_data[2]  = BRANCH;
    ifc.branches_taken = 3'b100;
    ifc.target_PCs[2]  = 32'h300;
    #1 check("last_valid", 32'(ifc.inst_valid), 32'd3);
    tick();
    check("last_next", ifc.PCs_out[0], 32'h300);

    // Buffer space limit, then restore
    do_reset();
    ifc.inst_buffer_spots = 2'd1;
    #1 check("spots1_valid", 32'(ifc.inst_valid), 32'd1);
    tick();
    check("spots1_next", ifc.PCs_out[0], 32'h04);
    @(negedge clk);
    ifc.restore_valid = 1'b1;
    ifc.PC_restore    = 32'h200;
    tick();
    check("restore_pc", ifc.PCs_out[0], 32'h200);
    @(negedge clk);
    ifc.restore_valid     = 1'b0;
    ifc.inst_buffer_spots = 2'd0;
    #1 check("spots0_valid", 32'(ifc.inst_valid), 32'd0);
    tick();
    check("spots0_hold", ifc.PCs_out[0], 32'h200);

    // Reset beats restore
    @(negedge clk);
    ifc.restore_valid = 1'b1;
    ifc.PC_restore    = 32'h500;
    rst               = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_over_restore", ifc.PCs_out[0], 32'h0);

    // Branches in slots 0 and 2
    do_reset();
    ifc.cache_data[0] = BRANCH;
    ifc.cache_data[2] = BRANCH;
    #1;
    check("br2_valid", 32'(ifc.inst_valid), 32'd3);
    check("br2_gntbus", 32'(ifc.branch_gnt_bus), 32'({3'b000, 3'b100, 3'b001}));
    check("br2_final", 32'(ifc.final_branch_gnt_line), 32'b100);
    ifc.cache_miss = 3'b100;
    #1;
    check("br2m_final", 32'(ifc.final_branch_gnt_line), 32'b001);
    check("br2m_gntbus", 32'(ifc.branch_gnt_bus), 32'({3'b000, 3'b100, 3'b001}));

    // JAL with BTB hit in slot 0, JALR in slot 2
    do_reset();
    ifc.cache_data[0] = JAL;
    ifc.cache_data[2] = JALR;
    ifc.btb_hits      = 3'b001;
    ifc.target_PCs[0] = 32'h40;
    #1;
    check("jal_isjump", 32'(ifc.inst_buffer_inputs[0].is_jump), 32'd1);
    check("jal_pred", 32'(ifc.inst_buffer_inputs[0].predict_taken), 32'd1);
    check("jal_ppc", ifc.inst_buffer_inputs[0].predicted_pc, 32'h40);
    check("jal_inst", ifc.inst_buffer_inputs[0].inst, JAL);
    check("jalr_isjump", 32'(ifc.inst_buffer_inputs[2].is_jump), 32'd1);
    check("nop_isjump", 32'(ifc.inst_buffer_inputs[1].is_jump), 32'd0);
    check("jal_nobr", 32'(ifc.no_branches_fetched), 32'd1);

    // PC wraparound
    @(negedge clk);
    defaults();
    ifc.restore_valid = 1'b1;
    ifc.PC_restore    = 32'hFFFF_FFF8;
    tick();
    @(negedge clk);
    ifc.restore_valid = 1'b0;
    #1;
    check("wrap_pc2", ifc.PCs_out[2], 32'h0);
    check("wrap_ppc2", ifc.inst_buffer_inputs[2].predicted_pc, 32'h4);
    tick();
    check("wrap_next", ifc.PCs_out[0], 32'h4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter N, default 3, fetch width in instructions (slots).
REQ-002 Parameter SB, default $clog2(N+1), width of count fields.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 PCs_out  out  N x 32  slot PCs sent to I-cache, BP and BTB.
REQ-007 cache_data  in  N x 32  instruction words per slot.
REQ-008 cache_miss  in  N  per-slot miss flag.
REQ-009 PC_restore  in  32  mispredict recovery PC.
REQ-010 restore_valid  in  1  recovery request.
REQ-011 inst_buffer_spots  in  SB  free instruction-buffer entries.
REQ-012 inst_buffer_inputs  out  N x FETCH_PACKET  per-slot packets.
REQ-013 inst_valid  out  SB  number of leading slots accepted.
REQ-014 bp_packets  in  N x BRANCH_PREDICTOR_PACKET  predictor state per slot.
REQ-015 branches_taken  in  N  per-slot taken prediction.
REQ-016 branch_gnt_bus  out  N x N  lowest-first one-hot grants over branch slots.
REQ-017 final_branch_gnt_line  out  N  one-hot of youngest accepted branch.
REQ-018 no_branches_fetched  out  1  no accepted branch.
REQ-019 target_PCs  in  N x 32  BTB targets; btb_hits  in  N  BTB hit flags.

Function
REQ-020 PC_reg (32 b) is the only state; slot PC[i] = PC_reg + 4*i for i=0..N (PC[N] used internally); PCs_out[i] = PC[i]; add wraps modulo 2^32.
REQ-021 Slot i is a branch when cache_data[i][6:0] == 7'b1100011; a jump when opcode is 7'b1101111 (JAL) or 7'b1100111 (JALR).
REQ-022 Limit vector = cache_miss | (branches_taken << 1), truncated to N bits; k = index of its lowest set bit; raw count = N if vector zero else k.
REQ-023 inst_valid = min(raw count, inst_buffer_spots).
REQ-024 Packet i (all slots, independent of inst_valid): inst = cache_data[i]; PC = PC[i]; predict_taken = (branch[i] && branches_taken[i]) || jump[i]; bp_packet = bp_packets[i]; predicted_PC = btb_hits[i] ? target_PCs[i] : PC[i+1]; is_jump = jump[i].
REQ-025 branch_gnt_bus row j = one-hot of the j-th lowest set bit of the unmasked branch vector; rows beyond the number of branches are zero.
REQ-026 Masked branch vector = branch[i] && i < inst_valid; final_branch_gnt_line = one-hot of its highest set bit; no_branches_fetched = 1 iff it is zero (grant line then zero).
REQ-027 Next PC: if inst_valid != 0 and branches_taken[inst_valid-1], target_PCs[inst_valid-1]; else PC[inst_valid].
REQ-028 Rising edge: reset -> PC_reg = 0; else restore_valid -> PC_reg = PC_restore; else PC_reg = next PC. Priority reset > restore > next.
REQ-029 All outputs combinational from PC_reg and inputs; zero-cycle latency; no simulation print statements.

Reset
REQ-030 After reset PC_reg = 0, so PCs_out = {0x0, 0x4, 0x8} for N=3; all other outputs follow REQ-022..027.

Structure
REQ-031 FETCH_PACKET, BRANCH_PREDICTOR_PACKET, N, opcode constants live in the shared package.
REQ-032 One generic sub-module prio_sel (parameters WIDTH, REQS, LSB_FIRST) provides one-hot grants, grant bus and empty flag; instantiated three times; one-hot-to-index encoding is inline.

Verification
REQ-033 Reset, no misses/taken, spots=3 -> inst_valid=3, next PC_reg=0x0C.
REQ-034 cache_miss=3'b100 -> inst_valid=2, next PC_reg=0x08.
REQ-035 Branch in slot 1, branches_taken=3'b010, target_PCs[1]=0x100 -> inst_valid=2, next PC_reg=0x100, packet1.predict_taken=1.
REQ-036 spots=1, no limits -> inst_valid=1, next PC_reg=0x04; restore_valid=1, PC_restore=0x200 simultaneously -> PC_reg=0x200.
REQ-037 Branches in slots 0 and 2, inst_valid=3 -> branch_gnt_bus={000,100,001} (rows 2..0), final_branch_gnt_line=100; add cache_miss=3'b100 -> final=001.
REQ-038 JAL in slot 0, btb_hits[0]=1, target 0x40 -> packet0.is_jump=1, predict_taken=1, predicted_PC=0x40.
